// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
//   Instr      [19:0] : instruction bits [31:12] from the instruction register
//   ALUFlags   [3:0]  : combinational ALU flags {N,Z,C,V}
//   PCWrite, MemWrite, RegWrite, IRWrite : datapath/memory write strobes
//   AdrSrc            : memory address select (0=PC, 1=ALUOut)
//   RegSrc     [1:0]  : bit0 selects R15 as RA1, bit1 selects Rd as RA2
//   ALUSrcA    [1:0]  : 00=PC, 01=A, 10=zero
//   ALUSrcB    [1:0]  : 00=WriteData, 01=ExtImm, 10=constant 4
//   ResultSrc  [1:0]  : 00=ALUResult, 01=ALUOut, 10=ReadData
//   ImmSrc     [1:0]  : immediate extension select (Instr[27:26])
//   ALUControl [1:0]  : 00=add, 01=sub, 10=and, 11=orr
//   state      [3:0]  : current FSM state code (debug/verification)
// The master modport is the controller; the slave modport is the datapath.
interface multicycle_ctrl_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;
  logic [3:0]  state;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    output RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, state
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    input  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset controller: a Moore FSM sequencing fetch, decode,
// memory, data-processing and branch steps, plus the NZCV flags register
// and condition evaluation.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (state=FETCH, flags=0000,
//           write strobes held low while asserted)
//   bus   : multicycle_ctrl_if.master -- instruction/flags in, controls out
module multicycle_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.master     bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;

  // Instruction fields (Instr holds bits [31:12])
  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       u_bit;
  logic       sl_bit;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign i_bit     = bus.Instr[13];
  assign cmd       = bus.Instr[12:9];
  assign u_bit     = bus.Instr[11];
  assign sl_bit    = bus.Instr[8];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  // Condition evaluation against the registered flags
  logic n_f, z_f, c_f, v_f;
  logic cond_ex;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Data-processing command decode
  logic [1:0] dp_alu_ctl;
  logic       dp_arith;
  logic       dp_cmp;
  logic       dp_noop;

  always_comb begin
    dp_alu_ctl = 2'b00;
    dp_arith   = 1'b0;
    dp_cmp     = 1'b0;
    dp_noop    = 1'b0;
    case (cmd)
      4'b0100: begin dp_alu_ctl = 2'b00; dp_arith = 1'b1; end
      4'b0010: begin dp_alu_ctl = 2'b01; dp_arith = 1'b1; end
      4'b0000: dp_alu_ctl = 2'b10;
      4'b1100: dp_alu_ctl = 2'b11;
      4'b1010: begin dp_alu_ctl = 2'b01; dp_arith = 1'b1; dp_cmp = 1'b1; end
      default: dp_noop = 1'b1;
    endcase
  end

  // Next-state, flags and held-condition logic
  always_comb begin
    state_d  = S_FETCH;
    flags_d  = flags_q;
    condex_d = condex_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = sl_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI: begin
        state_d  = S_ALUWB;
        // The write-back step must see the condition as it stood before
        // this instruction's own flag update, so capture it here.
        condex_d = cond_ex;
        if (sl_bit && cond_ex && !dp_noop) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (dp_arith) flags_d[1:0] = bus.ALUFlags[1:0];
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= '0;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  // Moore output decode. Kept combinational from state_q because several
  // outputs depend on the instruction register, which loads on the FETCH
  // edge and so is not yet valid when a registered output would be computed.
  logic       pc_write, mem_write, reg_write, ir_write, adr_src;
  logic [1:0] reg_src, alu_src_a, alu_src_b, result_src, alu_control;
  logic       wb_en;

  assign wb_en = condex_q & ~(dp_cmp | dp_noop);

  always_comb begin
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    reg_src     = '0;
    alu_src_a   = '0;
    alu_src_b   = '0;
    result_src  = '0;
    alu_control = '0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b  = 2'b10;
        reg_src[0] = (op == 2'b10);
        reg_src[1] = (op == 2'b01) && !sl_bit;
      end
      S_MEMADR: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        alu_control = u_bit ? 2'b00 : 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = cond_ex;
      end
      S_MEMWB: begin
        result_src = 2'b10;
        if (rd == 4'hF) pc_write  = cond_ex;
        else            reg_write = cond_ex;
      end
      S_EXECR: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b00;
        alu_control = dp_alu_ctl;
      end
      S_EXECI: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        alu_control = dp_alu_ctl;
      end
      S_ALUWB: begin
        result_src = 2'b01;
        if (rd == 4'hF) pc_write  = wb_en;
        else            reg_write = wb_en;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        pc_write  = cond_ex;
      end
      default: ;
    endcase
  end

  // Write strobes are held low for the whole reset pulse
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.RegSrc     = reg_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = op;
  assign bus.ALUControl = alu_control;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [3:0]  m_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic pcw, input logic mw, input logic rw,
                                     input logic irw, input logic adr, input logic [1:0] rsrc,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] res, input logic [1:0] imm,
                                     input logic [1:0] aluc);
    return {15'd0, pcw, mw, rw, irw, adr, rsrc, sa, sb, res, imm, aluc};
  endfunction

  function automatic logic [31:0] obs();
    return mk(bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
              bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
              bus.ALUControl);
  endfunction

  function automatic logic [31:0] strobes();
    return {28'd0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite};
  endfunction

  // Condition pass: even codes test a predicate, odd codes its inverse
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c[0] == 1'b0);
    endcase
    return c[0] ? !base : base;
  endfunction

  // Runs one instruction from FETCH; caller is positioned at a falling edge
  // with the controller in FETCH.
  task automatic run_instr(input string name, input logic [19:0] ins, input logic [3:0] af);
    logic [3:0]  cond, cmd, rd;
    logic [1:0]  op, aluc;
    logic        ib, u, sl;
    bit          pass, noop, cmp, arith, wr;
    logic [3:0]  st[$];
    logic [31:0] ex[$];
    cond = ins[19:16]; op = ins[15:14]; ib = ins[13]; cmd = ins[12:9];
    u = ins[11]; sl = ins[8]; rd = ins[3:0];
    pass = cond_pass(cond, m_flags);
    noop = 1'b0; cmp = 1'b0; arith = 1'b0; aluc = 2'b00;
    case (cmd)
      4'b0100: arith = 1'b1;
      4'b0010: begin aluc = 2'b01; arith = 1'b1; end
      4'b0000: aluc = 2'b10;
      4'b1100: aluc = 2'b11;
      4'b1010: begin aluc = 2'b01; arith = 1'b1; cmp = 1'b1; end
      default: noop = 1'b1;
    endcase

    st.push_back(4'd0); ex.push_back(mk(1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 2'b00, op, 2'b00));
    st.push_back(4'd1); ex.push_back(mk(0, 0, 0, 0, 0, {(op == 2'b01) && !sl, op == 2'b10},
                                        2'b00, 2'b10, 2'b00, op, 2'b00));
    case (op)
      2'b00: begin
        wr = pass && !cmp && !noop;
        st.push_back(ib ? 4'd7 : 4'd6);
        ex.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, ib ? 2'b01 : 2'b00, 2'b00, op, aluc));
        st.push_back(4'd8);
        ex.push_back(mk(wr && rd == 4'hF, 0, wr && rd != 4'hF, 0, 0, 2'b00, 2'b00, 2'b00,
                        2'b01, op, 2'b00));
      end
      2'b01: begin
        st.push_back(4'd2);
        ex.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, op, u ? 2'b00 : 2'b01));
        if (sl) begin
          st.push_back(4'd3);
          ex.push_back(mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op, 2'b00));
          st.push_back(4'd4);
          ex.push_back(mk(pass && rd == 4'hF, 0, pass && rd != 4'hF, 0, 0, 2'b00, 2'b00, 2'b00,
                          2'b10, op, 2'b00));
        end else begin
          st.push_back(4'd5);
          ex.push_back(mk(0, pass, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, op, 2'b00));
        end
      end
      2'b10: begin
        st.push_back(4'd9);
        ex.push_back(mk(pass, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, op, 2'b00));
      end
      default: ;
    endcase

    bus.Instr    = ins;
    bus.ALUFlags = af;
    #1;
    for (int k = 0; k < st.size(); k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      check($sformatf("%s.state%0d", name, k), {28'd0, bus.state}, {28'd0, st[k]});
      check($sformatf("%s.outs%0d", name, k), obs(), ex[k]);
    end
    if (op == 2'b00 && sl && pass && !noop)
      m_flags = {af[3:2], arith ? af[1:0] : m_flags[1:0]};
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s.done", name), {28'd0, bus.state}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.Instr    = '0;
    bus.ALUFlags = '0;
    m_flags      = '0;
    #1;
    check("rst.state", {28'd0, bus.state}, 32'd0);
    check("rst.strobes", strobes(), 32'd0);
    @(posedge clk);
    #1;
    check("rst.hold", strobes(), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr("add",      20'hE0800, 4'b0000);
    run_instr("ldr",      20'hE5910, 4'b0000);
    run_instr("cmp_z",    20'hE1500, 4'b0100);
    run_instr("beq_t",    20'h0A000, 4'b0000);
    run_instr("cmp_nz",   20'hE1500, 4'b0000);
    run_instr("beq_nt",   20'h0A000, 4'b0000);
    run_instr("cmp_z2",   20'hE1500, 4'b0100);
    run_instr("strne",    20'h15810, 4'b0000);
    run_instr("op11",     20'hEC000, 4'b1111);
    run_instr("addseq",   20'h0091F, 4'b0000);
    run_instr("ldr_pc",   20'hE591F, 4'b0000);

    // Asynchronous reset pulse in MEMREAD; flags hold Z=1 beforehand
    run_instr("cmp_z3",   20'hE1500, 4'b0100);
    bus.Instr = 20'hE5910;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      check($sformatf("abort.state%0d", k), {28'd0, bus.state}, k);
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort.async_state", {28'd0, bus.state}, 32'd0);
    check("abort.strobes", strobes(), 32'd0);
    @(posedge clk);
    #1;
    check("abort.hold_state", {28'd0, bus.state}, 32'd0);
    check("abort.hold_strobes", strobes(), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    m_flags = '0;
    run_instr("beq_after_rst", 20'h0A000, 4'b0000);

    for (int n = 0; n < 300; n++) begin
      logic [19:0] ins;
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
      run_instr($sformatf("rnd%0d", n), ins, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: Instr  in  20  instruction bits [31:12] from the instruction register.
REQ-004 SHALL have ports: ALUFlags  in  4  combinational ALU flags {N,Z,C,V}.
REQ-005 SHALL have ports: PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath/memory strobes and address select (0=PC, 1=ALUOut).
REQ-006 SHALL have ports: RegSrc  out  2  bit0=1 selects R15 as RA1; bit1=1 selects Rd as RA2.
REQ-007 SHALL have ports: ALUSrcA  out  2  00=PC, 01=A, 10=zero.
REQ-008 SHALL have ports: ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4.
REQ-009 SHALL have ports: ResultSrc  out  2  00=ALUResult, 01=ALUOut, 10=ReadData.
REQ-010 SHALL have ports: ImmSrc, ALUControl  out  2 each  ImmSrc=Instr[27:26]; ALUControl 00=add, 01=sub, 10=and, 11=orr.
REQ-011 SHALL have ports: state  out  4  current FSM state code, for debug and verification.

Function
REQ-012 SHALL implement a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH.
REQ-013 SHALL use these transitions:
- FETCH->DECODE.
- DECODE on Op=01 -> MEMADR; Op=00 with I=Instr[25]=0 -> EXECR; Op=00 with I=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH.
- MEMADR on L=Instr[20]=1 -> MEMREAD, else -> MEMWRITE; MEMREAD->MEMWB.
- EXECR/EXECI->ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
REQ-014 FETCH SHALL drive: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=00, ResultSrc=00, PCWrite=1.
REQ-015 DECODE SHALL drive ALUSrcA=00 and ALUSrcB=10, RegSrc[0]=(Op==10), and RegSrc[1]=(Op==01 and L==0).
REQ-016 MEMADR SHALL drive ALUSrcA=01, ALUSrcB=01, ALUControl=00 if U=Instr[23]=1, else 01.
REQ-017 MEMREAD SHALL drive AdrSrc=1; MEMWRITE SHALL drive AdrSrc=1 and MemWrite=CondEx.
REQ-018 MEMWB SHALL drive ResultSrc=10 and RegWrite=CondEx; when Rd=Instr[15:12]=1111 it SHALL drive PCWrite=CondEx and RegWrite=0.
REQ-019 EXECR SHALL drive ALUSrcA=01, ALUSrcB=00; EXECI SHALL drive ALUSrcA=01, ALUSrcB=01. In both, ALUControl SHALL be decoded from cmd=Instr[24:21]: ADD 0100->00, SUB 0010->01, AND 0000->10, ORR 1100->11, CMP 1010->01; any other cmd -> 00, marked NoOp.
REQ-020 ALUWB SHALL drive ResultSrc=01 and RegWrite=CondEx, except for CMP/NoOp, where RegWrite=0. When Rd=1111 (and not CMP/NoOp), it SHALL drive PCWrite=CondEx and RegWrite=0.
REQ-021 BRANCH SHALL drive ALUSrcA=01, ALUSrcB=01, ALUControl=00, ResultSrc=00, PCWrite=CondEx.
REQ-022 Outputs not listed for a state SHALL be 0.
REQ-023 SHALL hold a 4-bit NZCV flags register. CondEx SHALL be evaluated from cond=Instr[31:28] against the registered flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1110 true, 1111 false.
REQ-024 In EXECR/EXECI, when S=Instr[20]=1 and CondEx=1, the flags register SHALL load on that clock edge:
- N,Z for all cmds.
- C,V only for ADD/SUB/CMP.
- NoOp cmds SHALL NOT update flags.
REQ-025 CondEx for the instruction SHALL use the flags value held before the instruction's own update.
REQ-026 Instruction latency SHALL be: data-processing 4 cycles, LDR 5, STR 4, B 3, Op=11 2.

Reset
REQ-027 Reset assertion SHALL set state=FETCH and flags=0000 immediately, independent of clk.
REQ-028 While reset=1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced 0.
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction with no further strobes. On the first rising edge after release, the block SHALL execute FETCH.

Verification
REQ-030 Reset, then Instr=0xE080 (ADD R0,R0,R1): state sequence SHALL be 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUControl=00 in EXECR.
REQ-031 Instr=0xE591 (LDR, L=1, U=1): state sequence SHALL be 0,1,2,3,4; AdrSrc=1 in MEMREAD; ResultSrc=10 and RegWrite=1 in MEMWB.
REQ-032 CMP with S=1 (0xE15x) with ALUFlags=0100: flags SHALL become 0100 and RegWrite SHALL stay 0. A following BEQ (0x0Axx) SHALL assert PCWrite=1 in BRANCH; with flags=0000 the same BEQ SHALL leave PCWrite=0.
REQ-033 STR (0xE581) with cond=0001 (NE) and Z=1: MemWrite SHALL stay 0 in MEMWRITE and state SHALL return to FETCH after 4 cycles.
REQ-034 Reset pulsed asynchronously during MEMREAD: state SHALL read 0 before the next clk edge, all strobes SHALL be 0 during reset, and FETCH SHALL run after release.
REQ-035 Instr Op=11: sequence SHALL be 0,1,0 with no RegWrite, MemWrite or flag change.
